keypad_key_fifo: RTL and testbench
==================================

Name: keypad_key_fifo

Overview:
- Sits directly downstream of the hex keypad scanner/encoder. Consumes its 4-bit key code and its valid strobe.
- Turns each physical key press into exactly one queued code. Bounce and rescan pulses are suppressed by a release-quiet lockout.
- Buffers codes in a small FIFO that a host (display driver, command decoder) drains with a read handshake.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- AW, 3, pointer width; equals log2(DEPTH).
- QUIET, 16, consecutive cycles with code_valid low required before a new press is accepted; range 1..255.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; returns the whole block to its reset state.
- code_in  in  4  key code from the scanner, 0x0..0xF.
- code_valid  in  1  scanner valid strobe; sampled every rising edge.
- rd_en  in  1  host read request; pops one entry when not empty.
- rd_data  out  4  registered output code.
- rd_valid  out  1  one-cycle pulse; rd_data is valid in that cycle.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  AW+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a press was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of overflow.
- busy  out  1  high while the press FSM is in LOCK.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, empty=1, full=0, count=0, overflow=0, busy=0. Pointers are 0 and the FSM is in IDLE.
- Press FSM, 2 states, with an 8-bit quiet counter qcnt:
  - IDLE: code_valid=1 → capture code_in as a push request this cycle, load qcnt=0, go to LOCK.
  - LOCK: code_valid=1 → qcnt=0, no push. code_valid=0 → qcnt+1. qcnt reaching QUIET-1 while code_valid=0 → go to IDLE.
  - Re-arm timing: a press is re-armed after exactly QUIET consecutive low cycles. The earliest accepted next press is the cycle after the FSM enters IDLE.
  - busy = (state==LOCK).
- Push: registered on the same edge that samples code_valid in IDLE. The entry is visible one cycle later (empty falls, count increments).
- Pop: rd_en=1 and empty=0 → rd_data <= mem[rd_ptr], rd_valid=1 in the next cycle, rd_ptr+1.
  - rd_en while empty: ignored. rd_valid=0, rd_data holds its last value.
- Pointers wrap modulo DEPTH. count = pushes − pops, never outside 0..DEPTH.
- Simultaneous push and pop:
  - Not empty: both happen and count is unchanged.
  - Full: both happen; the pop frees the slot, no overflow.
  - Empty: only the push happens. The read is ignored (no bypass) and count becomes 1.
- Push when full and no pop: the code is discarded and overflow <= 1. The FSM still enters LOCK, so the dropped press is not retried.
- ovf_clr=1 clears overflow. If an overflow event occurs in the same cycle, overflow stays 1 (set wins).
- Reset mid-operation: all contents are discarded immediately and outputs return to reset values asynchronously. A pending LOCK is abandoned.
- code_in is only sampled in IDLE. Changes during LOCK have no effect.

Test Plan:
- Reset, then code_valid pulse 1 cycle with code_in=0xA, then quiet → count=1, empty=0 one cycle later. rd_en 1 cycle → rd_valid pulse with rd_data=0xA, count=0, empty=1.
- Bounce: code_valid pulses at t=0,3,7,12 with code_in=0x5, then 20 cycles low (QUIET=16) → exactly one entry 0x5. busy falls 16 cycles after the last pulse. A pulse with 0x6 at quiet-cycle 15 is rejected; the same pulse at quiet-cycle 17 is accepted.
- Ordering and wrap: 12 separated presses 0x0..0xB with reads interleaved after every 3rd press → read stream 0x0..0xB in order, pointers wrap, count never exceeds 8.
- Overflow: 9 separated presses 0x1..0x9, no reads → full=1, count=8, overflow=1, reads return 0x1..0x8. ovf_clr → overflow=0.
- Full with simultaneous press and rd_en → no overflow, count stays 8, the new code lands last. Separately, rd_en on empty → no rd_valid.
- Assert reset for 1 cycle while in LOCK with count=3 → count=0, empty=1, busy=0 immediately. The next code_valid is accepted at once.

Source files
------------

// File: rtl/keypad_key_fifo.sv
// -----------------------------------------------------------------------------
// keypad_key_fifo
//
// Purpose:
//   Sits behind the hex keypad scanner/encoder. Each physical key press is
//   turned into exactly one queued 4-bit code: a small press FSM accepts the
//   first valid strobe, then locks out until code_valid has stayed low for
//   QUIET consecutive cycles. That lockout swallows contact bounce and
//   rescan pulses. Accepted codes go into a DEPTH-entry FIFO, which the host
//   drains with a one-cycle read request.
//
// Parameters:
//   DEPTH  FIFO entries. Must be a power of 2 and at least 2.
//   AW     Pointer width. Must equal log2(DEPTH).
//   QUIET  Low cycles needed to re-arm the press detector, 1..255.
//
// Ports:
//   clock       in   system clock, rising-edge active
//   reset       in   asynchronous, active-high reset of the whole block
//   code_in     in   [3:0] key code from the scanner
//   code_valid  in   scanner valid strobe
//   rd_en       in   host read request; pops one entry when not empty
//   rd_data     out  [3:0] registered read data
//   rd_valid    out  one-cycle pulse qualifying rd_data
//   empty       out  FIFO holds no entries
//   full        out  FIFO holds DEPTH entries
//   count       out  [AW:0] occupancy, 0..DEPTH
//   overflow    out  sticky: a press was dropped because the FIFO was full
//   ovf_clr     in   synchronous clear of overflow (a new drop wins)
//   busy        out  press FSM is in its lockout state
// -----------------------------------------------------------------------------
module keypad_key_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int QUIET = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    code_in,
    input  logic          code_valid,
    input  logic          rd_en,
    output logic [3:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          busy
);

    // ------------------------------------------------------------------
    // Constants sized to the signals they are compared with
    // ------------------------------------------------------------------
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [7:0]    QUIET_LAST = 8'(QUIET - 1);

    // ------------------------------------------------------------------
    // Press FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] qcnt_reg;
    logic [7:0] qcnt_next;
    logic       push_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            qcnt_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            qcnt_reg  <= qcnt_next;
        end
    end

    // In LOCK, qcnt counts consecutive low samples. Any high sample restarts
    // the count. The FSM leaves on the QUIET-th consecutive low sample, so
    // the earliest new press is sampled on the following edge.
    always_comb begin
        state_next = state_reg;
        qcnt_next  = qcnt_reg;
        push_req   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (code_valid) begin
                    push_req   = 1'b1;
                    qcnt_next  = 8'd0;
                    state_next = LOCK;
                end
            end
            LOCK: begin
                if (code_valid) begin
                    qcnt_next = 8'd0;
                end else if (qcnt_reg == QUIET_LAST) begin
                    qcnt_next  = 8'd0;
                    state_next = IDLE;
                end else begin
                    qcnt_next = qcnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                qcnt_next  = 8'd0;
            end
        endcase
    end

    assign busy = (state_reg == LOCK);

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;
    logic          ovf_event;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == COUNT_FULL);
    assign count = count_reg;

    // A pop is only honoured when an entry is already stored, so a read
    // on an empty FIFO never bypasses a push arriving in the same cycle.
    // When full, a same-cycle pop frees the slot the push needs.
    assign do_pop    = rd_en & ~empty;
    assign do_push   = push_req & (~full | do_pop);
    assign ovf_event = push_req & full & ~do_pop;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + COUNT_ONE;
            2'b01:   count_next = count_reg - COUNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Storage array has no reset. Reset empties the FIFO by clearing the
    // pointers and the count, so stale words are never read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= code_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rd_data    <= 4'h0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            count_reg <= count_next;
            rd_valid  <= do_pop;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            // When full and pushing in the same cycle, both pointers address
            // the same slot. The read returns the old word before it is
            // overwritten.
            if (do_pop) begin
                rd_data    <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            // Set has priority over clear, so a drop in the clear cycle
            // is still reported.
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_key_fifo.sv
// -----------------------------------------------------------------------------
// tb_keypad_key_fifo
//
// Self-checking bench for keypad_key_fifo.
//
// Stimulus is a list of directed press/read sequences. When a press should
// reach the FIFO, the code it should later read back is pushed onto exp_q.
// A monitor on the falling edge pops exp_q whenever rd_valid is high and
// compares the popped code with rd_data. Status outputs (count, flags, busy)
// are checked inline, 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_keypad_key_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int QUIET = 16;

    logic        clock;
    logic        reset;
    logic [3:0]  code_in;
    logic        code_valid;
    logic        rd_en;
    logic [3:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overflow;
    logic        ovf_clr;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int mcount;

    logic [3:0] exp_q[$];

    keypad_key_fifo #(.DEPTH(DEPTH), .AW(AW), .QUIET(QUIET)) dut (
        .clock      (clock),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard monitor: each read pulse must match the oldest expected code.
    always @(negedge clock) begin
        if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_stream: got %0h expected no read", rd_data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    failures++;
                    $display("FAIL rd_stream: got %0h expected %0h", rd_data, e);
                end else begin
                    $display("ok   rd_stream: %0h", rd_data);
                end
            end
        end
    end

    // Every wait in the bench is a fixed cycle count. This is only a backstop.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Single-cycle strobe, optionally with rd_en and ovf_clr in the same cycle.
    task automatic press(input logic [3:0] c, input bit rd, input bit clr);
        code_in    = c;
        code_valid = 1'b1;
        rd_en      = rd;
        ovf_clr    = clr;
        cycle();
        code_valid = 1'b0;
        rd_en      = 1'b0;
        ovf_clr    = 1'b0;
    endtask

    task automatic quiet();
        repeat (QUIET) cycle();
    endtask

    task automatic read();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        code_in    = 4'h0;
        code_valid = 1'b0;
        rd_en      = 1'b0;
        ovf_clr    = 1'b0;
        repeat (2) cycle();

        // ---- reset values ----
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        cycle();

        // ---- single press and read ----
        press(4'hA, 0, 0);
        exp_q.push_back(4'hA);
        check("t1_count", count, 1);
        check("t1_empty", empty, 0);
        check("t1_busy", busy, 1);
        quiet();
        read();
        check("t1_rd_valid", rd_valid, 1);
        check("t1_count_after", count, 0);
        check("t1_empty_after", empty, 1);

        // ---- bounce: pulses at t=0,3,7,12; code_in changes during LOCK ----
        code_in = 4'h5;
        for (int t = 0; t <= 12; t++) begin
            code_valid = (t == 0 || t == 3 || t == 7 || t == 12);
            if (t != 0) code_in = 4'hE;
            cycle();
        end
        code_valid = 1'b0;
        exp_q.push_back(4'h5);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 15) check("bounce_busy_k15", busy, 1);
            if (k == 16) check("bounce_busy_k16", busy, 0);
        end
        check("bounce_count", count, 1);
        read();

        // ---- re-arm edge: pulse at quiet-cycle 15 rejected, 17 accepted ----
        press(4'h3, 0, 0);
        exp_q.push_back(4'h3);
        repeat (14) cycle();
        press(4'h6, 0, 0);
        check("rearm_reject_count", count, 1);
        repeat (16) cycle();
        press(4'h6, 0, 0);
        exp_q.push_back(4'h6);
        check("rearm_accept_count", count, 2);
        quiet();
        read();
        read();
        check("rearm_drained", count, 0);

        // ---- ordering and wrap: 12 presses, two reads after every 3rd ----
        mcount = 0;
        for (int i = 0; i < 12; i++) begin
            press(4'(i), 0, 0);
            exp_q.push_back(4'(i));
            mcount++;
            check("wrap_count_push", count, mcount);
            quiet();
            if (i % 3 == 2) begin
                read();
                read();
                mcount -= 2;
                check("wrap_count_pop", count, mcount);
            end
        end
        repeat (4) read();
        check("wrap_empty", empty, 1);

        // ---- overflow: 9 presses, the 9th is dropped ----
        for (int i = 1; i <= 9; i++) begin
            press(4'(i), 0, 0);
            if (i <= 8) exp_q.push_back(4'(i));
            quiet();
        end
        check("ovf_full", full, 1);
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Drop in the same cycle as ovf_clr: set wins.
        press(4'hD, 0, 1);
        check("ovf_set_wins", overflow, 1);
        check("ovf_set_wins_count", count, 8);
        quiet();
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check("ovf_cleared2", overflow, 0);

        // Full with a simultaneous press and read: both happen.
        press(4'hC, 1, 0);
        exp_q.push_back(4'hC);
        check("full_rw_count", count, 8);
        check("full_rw_ovf", overflow, 0);
        check("full_rw_full", full, 1);
        quiet();
        repeat (8) read();
        check("full_rw_drained", empty, 1);

        // Read on empty is ignored, and rd_data holds its last value.
        read();
        check("empty_rd_valid", rd_valid, 0);
        check("empty_rd_hold", rd_data, 4'hC);

        // Press and read together on an empty FIFO: only the push happens.
        press(4'h7, 1, 0);
        exp_q.push_back(4'h7);
        check("empty_rw_count", count, 1);
        check("empty_rw_rd_valid", rd_valid, 0);
        quiet();
        read();

        // ---- asynchronous reset while in LOCK with 3 entries ----
        press(4'h1, 0, 0);
        quiet();
        press(4'h2, 0, 0);
        quiet();
        press(4'h3, 0, 0);
        check("rst_mid_count_before", count, 3);
        check("rst_mid_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_count", count, 0);
        check("rst_mid_empty", empty, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rd_data", rd_data, 0);
        cycle();
        reset = 1'b0;
        press(4'h9, 0, 0);
        exp_q.push_back(4'h9);
        check("post_rst_count", count, 1);
        check("post_rst_busy", busy, 1);
        quiet();
        read();

        repeat (3) cycle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
